// File: rtl/partsel_stream.sv
// Indexed part-select streamer: captures a wide word and emits SLICE_W-bit slices
// at an anchor that moves by STEP per accepted beat, using +: or -: semantics.
module partsel_stream #(
  parameter int DATA_W  = 256,
  parameter int SLICE_W = 8,
  parameter int STEP    = 8,
  parameter int CNT_W   = 8,
  parameter int WRAP    = 0,
  parameter int IDX_W   = $clog2(DATA_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [DATA_W-1:0]   load_data,
  input  logic [IDX_W-1:0]    start_idx,
  input  logic [CNT_W-1:0]    count,
  input  logic                dir,
  input  logic                rev,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SLICE_W-1:0]  out_data,
  output logic [IDX_W+1:0]    out_idx,
  output logic                out_oob,
  output logic                busy,
  output logic                done
);

  localparam int AW = IDX_W + 2;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   capWord_q, capWord_d;
  logic                dir_q, dir_d;
  logic                rev_q, rev_d;
  logic [CNT_W-1:0]    remain_q, remain_d;
  logic [AW-1:0]       anchor_q, anchor_d;
  logic [SLICE_W-1:0]  sliceData_q, sliceData_d;
  logic                sliceOob_q, sliceOob_d;
  logic                done_q, done_d;
  logic [AW-1:0]       stepRaw;
  logic [AW-1:0]       stepAnchor;
  logic [AW-1:0]       startAnchor;

  // Returns {oob, slice}; an index is in range exactly when its two top bits are 00.
  function automatic logic [SLICE_W:0] sliceOf(input logic [DATA_W-1:0] word,
                                               input logic [AW-1:0] anchor,
                                               input logic d, input logic r);
    logic [AW-1:0]      lo;
    logic [AW-1:0]      pos;
    logic [SLICE_W-1:0] s;
    logic               oob;
    logic               inRange;
    lo  = d ? anchor - AW'(SLICE_W - 1) : anchor;
    s   = '0;
    oob = 1'b0;
    for (int i = 0; i < SLICE_W; i++) begin
      pos     = lo + AW'(i);
      inRange = (pos[AW-1:IDX_W] == 2'b00);
      oob     = oob | ~inRange;
      s[i]    = (inRange || WRAP != 0) ? word[pos[IDX_W-1:0]] : 1'b0;
    end
    if (r) s = {<<{s}};
    return {oob, s};
  endfunction

  assign startAnchor = {2'b00, start_idx};
  assign stepRaw     = dir_q ? anchor_q - AW'(STEP) : anchor_q + AW'(STEP);
  assign stepAnchor  = (WRAP != 0) ? {2'b00, stepRaw[IDX_W-1:0]} : stepRaw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      capWord_q   <= '0;
      dir_q       <= 1'b0;
      rev_q       <= 1'b0;
      remain_q    <= '0;
      anchor_q    <= '0;
      sliceData_q <= '0;
      sliceOob_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      capWord_q   <= capWord_d;
      dir_q       <= dir_d;
      rev_q       <= rev_d;
      remain_q    <= remain_d;
      anchor_q    <= anchor_d;
      sliceData_q <= sliceData_d;
      sliceOob_q  <= sliceOob_d;
      done_q      <= done_d;
    end
  end

  // The slice for the next beat is computed here so the outputs come straight from flops.
  always_comb begin
    state_d     = state_q;
    capWord_d   = capWord_q;
    dir_d       = dir_q;
    rev_d       = rev_q;
    remain_d    = remain_q;
    anchor_d    = anchor_q;
    sliceData_d = sliceData_q;
    sliceOob_d  = sliceOob_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          if (count != '0) begin
            capWord_d = load_data;
            dir_d     = dir;
            rev_d     = rev;
            remain_d  = count;
            anchor_d  = startAnchor;
            {sliceOob_d, sliceData_d} = sliceOf(load_data, startAnchor, dir, rev);
            state_d   = SEND;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (out_ready) begin
          if (remain_q == CNT_W'(1)) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            remain_d    = '0;
            anchor_d    = '0;
            sliceData_d = '0;
            sliceOob_d  = 1'b0;
          end else begin
            remain_d = remain_q - CNT_W'(1);
            anchor_d = stepAnchor;
            {sliceOob_d, sliceData_d} = sliceOf(capWord_q, stepAnchor, dir_q, rev_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_data  = sliceData_q;
  assign out_idx   = anchor_q;
  assign out_oob   = sliceOob_q;
  assign done      = done_q;

endmodule

// File: tb/tb_partsel_stream.sv
// Scoreboard bench for partsel_stream: one WRAP=0 and one WRAP=1 instance share
// the same stimulus; each has its own expected-beat queue checked by a monitor.
module tb_partsel_stream;

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] idx;
    logic       oob;
    logic       last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         load = 1'b0;
  logic [255:0] loadData = '0;
  logic [7:0]   startIdx = '0;
  logic [7:0]   count = '0;
  logic         dir = 1'b0;
  logic         rev = 1'b0;
  logic         outReady = 1'b1;

  logic         outValid [2];
  logic [7:0]   outData  [2];
  logic [9:0]   outIdx   [2];
  logic         outOob   [2];
  logic         busy     [2];
  logic         done     [2];

  beat_t        q0[$];
  beat_t        q1[$];
  logic         doneNext [2] = '{1'b0, 1'b0};
  logic         armZero = 1'b0;
  int           total = 0;
  int           bad = 0;
  logic [255:0] patP;

  always #5 clk = ~clk;

  partsel_stream #(.WRAP(0)) dutZero (
    .clk(clk), .rst_n(rst_n), .load(load), .load_data(loadData),
    .start_idx(startIdx), .count(count), .dir(dir), .rev(rev),
    .out_valid(outValid[0]), .out_ready(outReady), .out_data(outData[0]),
    .out_idx(outIdx[0]), .out_oob(outOob[0]), .busy(busy[0]), .done(done[0])
  );

  partsel_stream #(.WRAP(1)) dutWrap (
    .clk(clk), .rst_n(rst_n), .load(load), .load_data(loadData),
    .start_idx(startIdx), .count(count), .dir(dir), .rev(rev),
    .out_valid(outValid[1]), .out_ready(outReady), .out_data(outData[1]),
    .out_idx(outIdx[1]), .out_oob(outOob[1]), .busy(busy[1]), .done(done[1])
  );

  task automatic checkOutput(input string name, input int u,
                             input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s dut%0d: got %0h want %0h at %0t", name, u, got, want, $time);
    end
  endtask

  task automatic expectBeat(input logic [7:0] d0, input logic [9:0] i0, input logic o0,
                            input logic [7:0] d1, input logic [9:0] i1, input logic o1,
                            input logic last);
    q0.push_back('{d0, i0, o0, last});
    q1.push_back('{d1, i1, o1, last});
  endtask

  task automatic applyStimulus(input logic [255:0] d, input logic [7:0] st,
                               input logic [7:0] cnt, input logic dr, input logic rv);
    @(posedge clk);
    #1;
    load     = 1'b1;
    loadData = d;
    startIdx = st;
    count    = cnt;
    dir      = dr;
    rev      = rv;
    if (cnt == 8'd0) armZero = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (!busy[0] && !busy[1] && q0.size() == 0 && q1.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput({name, "_finished"}, 0, 32'(ok), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic checkZeros(input string name);
    for (int u = 0; u < 2; u++) begin
      checkOutput({name, "_valid"}, u, 32'(outValid[u]), 32'd0);
      checkOutput({name, "_data"},  u, 32'(outData[u]),  32'd0);
      checkOutput({name, "_idx"},   u, 32'(outIdx[u]),   32'd0);
      checkOutput({name, "_oob"},   u, 32'(outOob[u]),   32'd0);
      checkOutput({name, "_busy"},  u, 32'(busy[u]),     32'd0);
      checkOutput({name, "_done"},  u, 32'(done[u]),     32'd0);
    end
  endtask

  // Monitor: compares the presented beat against the queue head every cycle it is
  // valid (so a stall must hold it), pops on transfer, and tracks the done pulse.
  always @(negedge clk) begin
    beat_t e;
    logic  haveExp;
    if (!rst_n) begin
      doneNext[0] = 1'b0;
      doneNext[1] = 1'b0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        checkOutput("done", u, 32'(done[u]), 32'(doneNext[u]));
        doneNext[u] = 1'b0;
        if (outValid[u]) begin
          haveExp = (u == 0) ? (q0.size() > 0) : (q1.size() > 0);
          if (!haveExp) begin
            checkOutput("unexpected_beat", u, 32'(outValid[u]), 32'd0);
          end else begin
            e = (u == 0) ? q0[0] : q1[0];
            checkOutput("beat_data", u, 32'(outData[u]), 32'(e.data));
            checkOutput("beat_idx",  u, 32'(outIdx[u]),  32'(e.idx));
            checkOutput("beat_oob",  u, 32'(outOob[u]),  32'(e.oob));
            if (outReady) begin
              if (u == 0) void'(q0.pop_front());
              else        void'(q1.pop_front());
              if (e.last) doneNext[u] = 1'b1;
            end
          end
        end
      end
      if (armZero) begin
        doneNext[0] = 1'b1;
        doneNext[1] = 1'b1;
        armZero     = 1'b0;
      end
    end
  end

  initial begin
    for (int k = 0; k < 32; k++) patP[k*8 +: 8] = 8'(k);
    patP[31:0]    = 32'hA5C3_0F81;
    patP[255:248] = 8'hDE;

    #2 rst_n = 1'b0;
    #1 checkZeros("reset");
    #19 rst_n = 1'b1;

    $display("[TB] ascending stream");
    expectBeat(8'h04, 10'd32, 1'b0, 8'h04, 10'd32, 1'b0, 1'b0);
    expectBeat(8'h05, 10'd40, 1'b0, 8'h05, 10'd40, 1'b0, 1'b0);
    expectBeat(8'h06, 10'd48, 1'b0, 8'h06, 10'd48, 1'b0, 1'b0);
    expectBeat(8'h07, 10'd56, 1'b0, 8'h07, 10'd56, 1'b0, 1'b1);
    applyStimulus(patP, 8'd32, 8'd4, 1'b0, 1'b0);
    waitIdle("ascending");

    $display("[TB] unaligned and descending");
    expectBeat(8'h4B, 10'd23, 1'b0, 8'h4B, 10'd23, 1'b0, 1'b1);
    applyStimulus(patP, 8'd23, 8'd1, 1'b0, 1'b0);
    waitIdle("unaligned");
    expectBeat(8'hA5, 10'd31, 1'b0, 8'hA5, 10'd31, 1'b0, 1'b0);
    expectBeat(8'hC3, 10'd23, 1'b0, 8'hC3, 10'd23, 1'b0, 1'b1);
    applyStimulus(patP, 8'd31, 8'd2, 1'b1, 1'b0);
    waitIdle("descending");

    $display("[TB] bit reversal");
    expectBeat(8'hF0, 10'd8, 1'b0, 8'hF0, 10'd8, 1'b0, 1'b1);
    applyStimulus(patP, 8'd8, 8'd1, 1'b0, 1'b1);
    waitIdle("reverse");

    $display("[TB] out of range high");
    expectBeat(8'h0D, 10'd252, 1'b1, 8'h1D, 10'd252, 1'b1, 1'b0);
    expectBeat(8'h00, 10'd260, 1'b1, 8'hF8, 10'd4,   1'b0, 1'b1);
    applyStimulus(patP, 8'd252, 8'd2, 1'b0, 1'b0);
    waitIdle("oob_high");

    $display("[TB] out of range low, descending");
    expectBeat(8'h10, 10'd3,     1'b1, 8'h1D, 10'd3,   1'b1, 1'b0);
    expectBeat(8'h00, 10'h3FB,   1'b1, 8'hE1, 10'd251, 1'b0, 1'b1);
    applyStimulus(patP, 8'd3, 8'd2, 1'b1, 1'b0);
    waitIdle("oob_low");

    $display("[TB] backpressure and load while busy");
    expectBeat(8'h08, 10'd64, 1'b0, 8'h08, 10'd64, 1'b0, 1'b0);
    expectBeat(8'h09, 10'd72, 1'b0, 8'h09, 10'd72, 1'b0, 1'b0);
    expectBeat(8'h0A, 10'd80, 1'b0, 8'h0A, 10'd80, 1'b0, 1'b0);
    expectBeat(8'h0B, 10'd88, 1'b0, 8'h0B, 10'd88, 1'b0, 1'b1);
    applyStimulus(patP, 8'd64, 8'd4, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    outReady = 1'b0;
    load     = 1'b1;
    loadData = '1;
    startIdx = 8'd0;
    count    = 8'd1;
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    outReady = 1'b1;
    waitIdle("stall");

    $display("[TB] zero count");
    applyStimulus(patP, 8'd16, 8'd0, 1'b0, 1'b0);
    waitIdle("zero_count");

    $display("[TB] reset mid-stream");
    expectBeat(8'h10, 10'd128, 1'b0, 8'h10, 10'd128, 1'b0, 1'b0);
    applyStimulus(patP, 8'd128, 8'd4, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkZeros("abort");
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    checkZeros("abort_hold");
    rst_n = 1'b1;
    expectBeat(8'h11, 10'd136, 1'b0, 8'h11, 10'd136, 1'b0, 1'b0);
    expectBeat(8'h12, 10'd144, 1'b0, 8'h12, 10'd144, 1'b0, 1'b1);
    applyStimulus(patP, 8'd136, 8'd2, 1'b0, 1'b0);
    waitIdle("after_reset");

    checkOutput("queue_empty", 0, 32'(q0.size()), 32'd0);
    checkOutput("queue_empty", 1, 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
